oflow_apb_master: RTL and testbench



---
 rtl/oflow_apb_master.sv | 145 ++++++++++++++
 tb/tb_oflow_apb_master.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oflow_apb_master.sv
// rtl/oflow_apb_master.sv - APB initiator for the oflow register file, fed by a 4-deep command FIFO
module oflow_apb_master #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 16,
  parameter int RD_DATA_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              apb_psel,
  output logic              apb_penable,
  output logic              apb_pwrite,
  output logic [ADDR_W-1:0] apb_addr,
  output logic [DATA_W-1:0] apb_pwdata,
  input  logic              apb_pready,
  input  logic [DATA_W-1:0] apb_prdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int EW = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RDWAIT} state_t;

  state_t        state;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] tcnt;
  logic [EW-1:0] head;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          timeout_hit;
  logic          to_rdwait;
  logic          xfer_done;
  logic          next_cmd;

  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == (AW+1)'(FIFO_DEPTH));
  assign cmd_ready   = !fifo_full;
  assign push        = cmd_valid && !fifo_full;
  assign head        = mem[rd_ptr];
  assign busy        = (state != IDLE) || !fifo_empty;

  // the TIMEOUT-th consecutive not-ready cycle is the one that sees tcnt == TIMEOUT-1
  assign timeout_hit = !apb_pready && (tcnt >= CW'(TIMEOUT - 1));
  assign to_rdwait   = (state == ACCESS) && apb_pready && !apb_pwrite && (RD_DATA_LAT != 0);
  assign xfer_done   = (state == ACCESS) && ((apb_pready && !to_rdwait) || timeout_hit);
  assign next_cmd    = (state == IDLE) || (state == RDWAIT) || xfer_done;
  assign pop         = next_cmd && !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state       <= IDLE;
      tcnt        <= '0;
      apb_psel    <= 1'b0;
      apb_penable <= 1'b0;
      apb_pwrite  <= 1'b0;
      apb_addr    <= '0;
      apb_pwdata  <= '0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: ;
        SETUP: begin
          state       <= ACCESS;
          apb_penable <= 1'b1;
          tcnt        <= '0;
        end
        ACCESS: begin
          if (!apb_pready && (tcnt != CW'(TIMEOUT))) tcnt <= tcnt + 1'b1;
          if (to_rdwait) begin
            state       <= RDWAIT;
            apb_psel    <= 1'b0;
            apb_penable <= 1'b0;
          end else if (xfer_done) begin
            rsp_valid <= 1'b1;
            rsp_write <= apb_pwrite;
            rsp_err   <= !apb_pready;
            rsp_rdata <= (apb_pready && !apb_pwrite) ? apb_prdata : '0;
          end
        end
        RDWAIT: begin
          rsp_valid <= 1'b1;
          rsp_write <= apb_pwrite;
          rsp_err   <= 1'b0;
          rsp_rdata <= apb_prdata;
        end
        default: state <= IDLE;
      endcase
      // chain straight into the next SETUP so back-to-back commands skip IDLE
      if (next_cmd) begin
        if (!fifo_empty) begin
          state                              <= SETUP;
          apb_psel                           <= 1'b1;
          apb_penable                        <= 1'b0;
          {apb_pwrite, apb_addr, apb_pwdata} <= head;
        end else begin
          state       <= IDLE;
          apb_psel    <= 1'b0;
          apb_penable <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_oflow_apb_master.sv
// tb/tb_oflow_apb_master.sv - self-checking bench for oflow_apb_master against a queue-based reference model
module tb_oflow_apb_master;

  typedef struct packed { logic w; logic [7:0] a; logic [31:0] d; } cmd_t;
  typedef struct packed { logic w; logic err; logic [31:0] rdata; } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_N;

  logic cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic psel, penable, pwrite, pready;
  logic [7:0] paddr;
  logic [31:0] pwdata, prdata;
  logic rsp_valid, rsp_write, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic c0_valid, c0_ready, c0_write;
  logic [7:0] c0_addr;
  logic [31:0] c0_wdata;
  logic psel0, penable0, pwrite0, pready0;
  logic [7:0] paddr0;
  logic [31:0] pwdata0, prdata0;
  logic rsp_valid0, rsp_write0, rsp_err0, busy0;
  logic [31:0] rsp_rdata0;

  oflow_apb_master #(.RD_DATA_LAT(1)) dut (
    .clk(clk), .reset_N(reset_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .apb_psel(psel), .apb_penable(penable), .apb_pwrite(pwrite),
    .apb_addr(paddr), .apb_pwdata(pwdata), .apb_pready(pready), .apb_prdata(prdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .busy(busy)
  );

  oflow_apb_master #(.RD_DATA_LAT(0)) dut0 (
    .clk(clk), .reset_N(reset_N),
    .cmd_valid(c0_valid), .cmd_ready(c0_ready), .cmd_write(c0_write),
    .cmd_addr(c0_addr), .cmd_wdata(c0_wdata),
    .apb_psel(psel0), .apb_penable(penable0), .apb_pwrite(pwrite0),
    .apb_addr(paddr0), .apb_pwdata(pwdata0), .apb_pready(pready0), .apb_prdata(prdata0),
    .rsp_valid(rsp_valid0), .rsp_write(rsp_write0), .rsp_err(rsp_err0),
    .rsp_rdata(rsp_rdata0), .busy(busy0)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [79:0] RST_OUTS = 80'h1;
  logic [79:0] outs1, outs0;
  assign outs1 = {psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_write, rsp_err, rsp_rdata, busy, cmd_ready};
  assign outs0 = {psel0, penable0, pwrite0, paddr0, pwdata0, rsp_valid0, rsp_write0, rsp_err0, rsp_rdata0, busy0, c0_ready};

  // registered-read slave: 0xFF is unmapped and never answers
  logic [31:0] sregs [256];
  int wait_mode = 0;
  int cur_wait = 0;
  int acc_cnt = 0;
  assign pready = psel && penable && (paddr != 8'hFF) && (acc_cnt >= cur_wait);
  always @(posedge clk) begin
    if (psel && !penable) cur_wait <= (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1; else acc_cnt <= 0;
    if (psel && penable && pready && pwrite) sregs[paddr] <= pwdata;
    if (psel && penable && pready && !pwrite) prdata <= sregs[paddr];
    else prdata <= $urandom;
  end

  // zero-latency slave for the RD_DATA_LAT=0 instance
  assign pready0 = psel0 && penable0;
  assign prdata0 = (psel0 && penable0) ? 32'h1234_5678 : 32'hDEAD_BEEF;

  logic [31:0] model [256];
  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];
  time  rsp_tq[$];
  int pushes = 0;
  int setups = 0;
  int rsp_cnt = 0;
  bit saw_full = 0;
  time push_t;
  logic [40:0] cur_xfer = '0;
  cmd_t mon_c;
  rsp_t mon_r;

  always @(negedge clk) begin
    if (!reset_N) begin
      setups = 0;
    end else begin
      if (psel && !penable) begin
        setups++;
        checks++;
        if (exp_cmd.size() == 0) begin
          errors++;
          $display("FAIL apb_setup unexpected addr %h", paddr);
        end else begin
          mon_c = exp_cmd.pop_front();
          if ({pwrite, paddr, pwdata} !== {mon_c.w, mon_c.a, mon_c.d}) begin
            errors++;
            $display("FAIL apb_cmd got %h want %h", {pwrite, paddr, pwdata}, mon_c);
          end
        end
        cur_xfer = {pwrite, paddr, pwdata};
      end
      if (psel && penable) begin
        checks++;
        if ({pwrite, paddr, pwdata} !== cur_xfer) begin
          errors++;
          $display("FAIL apb_stable got %h want %h", {pwrite, paddr, pwdata}, cur_xfer);
        end
      end
      checks++;
      if (cmd_ready !== ((pushes - setups) != 4)) begin
        errors++;
        $display("FAIL cmd_ready got %b with %0d queued", cmd_ready, pushes - setups);
      end
      if (rsp_valid) begin
        rsp_cnt++;
        rsp_tq.push_back($time);
        checks++;
        if (exp_rsp.size() == 0) begin
          errors++;
          $display("FAIL rsp unexpected pulse rdata %h", rsp_rdata);
        end else begin
          mon_r = exp_rsp.pop_front();
          if ({rsp_write, rsp_err, rsp_rdata} !== mon_r) begin
            errors++;
            $display("FAIL rsp got %h want %h", {rsp_write, rsp_err, rsp_rdata}, mon_r);
          end
        end
      end
    end
  end

  task automatic push(input logic w, input logic [7:0] a, input logic [31:0] d);
    int t;
    cmd_t c;
    rsp_t r;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    t = 0;
    while (!cmd_ready && t < 100) begin
      saw_full = 1'b1;
      @(negedge clk);
      t++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL push_wait cmd_ready stuck at %b want 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    push_t = $time;
    pushes++;
    c.w = w; c.a = a; c.d = d;
    exp_cmd.push_back(c);
    r.w = w;
    r.err = (a == 8'hFF);
    r.rdata = (w || a == 8'hFF) ? 32'h0 : model[a];
    if (w && a != 8'hFF) model[a] = d;
    exp_rsp.push_back(r);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic push0(input logic w, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    c0_valid = 1'b1; c0_write = w; c0_addr = a; c0_wdata = d;
    @(posedge clk);
    push_t = $time;
    #1 c0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < 2000);
    checks++;
    if (busy) begin errors++; $display("FAIL wait_idle busy got %b want 0", busy); end
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_rsp.size() != 0) begin
      errors++;
      $display("FAIL rsp_pending got %0d outstanding want 0", exp_rsp.size());
    end
  endtask

  task automatic test_reset();
    reset_N = 1'b0;
    #2;
    checks++;
    if (outs1 !== RST_OUTS) begin errors++; $display("FAIL reset_outs got %h want %h", outs1, RST_OUTS); end
    checks++;
    if (outs0 !== RST_OUTS) begin errors++; $display("FAIL reset_outs0 got %h want %h", outs0, RST_OUTS); end
    repeat (3) @(negedge clk);
    reset_N = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (outs1 !== RST_OUTS) begin errors++; $display("FAIL post_reset got %h want %h", outs1, RST_OUTS); end
  endtask

  task automatic test_single_write();
    wait_mode = 0;
    push(1'b1, 8'h04, 32'h0000_00A5);
    @(negedge clk);
    checks++;
    if ({psel, penable, busy} !== 3'b001) begin errors++; $display("FAIL sw_idle got %b want 001", {psel, penable, busy}); end
    @(negedge clk);
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata} !== {3'b101, 8'h04, 32'hA5}) begin
      errors++; $display("FAIL sw_setup got %h", {psel, penable, pwrite, paddr, pwdata});
    end
    @(negedge clk);
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata} !== {3'b111, 8'h04, 32'hA5}) begin
      errors++; $display("FAIL sw_access got %h", {psel, penable, pwrite, paddr, pwdata});
    end
    @(negedge clk);
    checks++;
    if ({psel, rsp_valid, rsp_write, rsp_err, rsp_rdata, busy} !== {4'b0110, 32'h0, 1'b0}) begin
      errors++; $display("FAIL sw_rsp got %h", {psel, rsp_valid, rsp_write, rsp_err, rsp_rdata, busy});
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sw_rsp_pulse got %b want 0", rsp_valid); end
  endtask

  task automatic test_write_read();
    wait_mode = 0;
    push(1'b1, 8'h08, 32'h0000_0007);
    wait_idle();
    push(1'b0, 8'h08, 32'h0);
    repeat (3) @(negedge clk);
    checks++;
    if ({psel, penable, pwrite} !== 3'b110) begin errors++; $display("FAIL wr_access got %b", {psel, penable, pwrite}); end
    @(negedge clk);
    checks++;
    if ({psel, penable, rsp_valid, busy} !== 4'b0001) begin
      errors++; $display("FAIL wr_rdwait got %b want 0001", {psel, penable, rsp_valid, busy});
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_write, rsp_err, rsp_rdata} !== {3'b100, 32'h7}) begin
      errors++; $display("FAIL wr_rdata got %h want 7", {rsp_valid, rsp_write, rsp_err, rsp_rdata});
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    wait_mode = 0;
    rsp_tq.delete();
    for (int i = 0; i < 4; i++) push(1'b1, 8'h10 + 8'(i), $urandom);
    wait_idle();
    checks++;
    if (rsp_tq.size() != 4) begin
      errors++; $display("FAIL b2b_count got %0d want 4", rsp_tq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rsp_tq[i+1] - rsp_tq[i] != 20) begin
          errors++; $display("FAIL b2b_spacing got %0t want 20", rsp_tq[i+1] - rsp_tq[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n0;
    wait_mode = 3;
    saw_full = 1'b0;
    n0 = rsp_cnt;
    for (int i = 0; i < 6; i++) push(1'b1, 8'h20 + 8'(i), $urandom);
    wait_idle();
    checks++;
    if (!saw_full) begin errors++; $display("FAIL bp_full got cmd_ready always 1 want a stall"); end
    checks++;
    if (rsp_cnt - n0 != 6) begin errors++; $display("FAIL bp_rsp_count got %0d want 6", rsp_cnt - n0); end
  endtask

  task automatic test_timeout(input logic follow);
    int acc;
    wait_mode = 0;
    push(follow, 8'hFF, 32'hCAFE_0001);
    if (follow) push(1'b1, 8'h30, 32'h0000_5A5A);
    acc = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (rsp_valid) break;
      if (psel && penable) acc++;
    end
    checks++;
    if (acc != 16) begin errors++; $display("FAIL to_cycles got %0d want 16", acc); end
    checks++;
    if ({rsp_valid, rsp_write, rsp_err, rsp_rdata} !== {1'b1, follow, 1'b1, 32'h0}) begin
      errors++; $display("FAIL to_rsp got %h", {rsp_valid, rsp_write, rsp_err, rsp_rdata});
    end
    checks++;
    if ({psel, penable} !== {follow, 1'b0}) begin
      errors++; $display("FAIL to_next got %b want %b", {psel, penable}, {follow, 1'b0});
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int n0;
    wait_mode = 3;
    push(1'b1, 8'hF0, 32'h1);
    push(1'b1, 8'hF1, 32'h2);
    push(1'b1, 8'hF2, 32'h3);
    @(negedge clk);
    #1;
    checks++;
    if ({psel, penable} !== 2'b11 || (pushes - setups) != 2) begin
      errors++; $display("FAIL rm_pre got %b queued %0d want 11 and 2", {psel, penable}, pushes - setups);
    end
    reset_N = 1'b0;
    #1;
    checks++;
    if (outs1 !== RST_OUTS) begin errors++; $display("FAIL rm_outs got %h want %h", outs1, RST_OUTS); end
    exp_cmd.delete();
    exp_rsp.delete();
    pushes = 0;
    n0 = rsp_cnt;
    repeat (2) @(negedge clk);
    reset_N = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (rsp_cnt != n0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rm_post got pulses %0d busy %b ready %b", rsp_cnt - n0, busy, cmd_ready);
    end
  endtask

  task automatic test_lat0();
    push0(1'b0, 8'h20, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({psel0, penable0} !== 2'b10) begin errors++; $display("FAIL l0_setup got %b want 10", {psel0, penable0}); end
    @(negedge clk);
    checks++;
    if ({psel0, penable0} !== 2'b11) begin errors++; $display("FAIL l0_access got %b want 11", {psel0, penable0}); end
    @(negedge clk);
    checks++;
    if ({rsp_valid0, rsp_write0, rsp_err0, rsp_rdata0, psel0} !== {3'b100, 32'h1234_5678, 1'b0}) begin
      errors++; $display("FAIL l0_rsp got %h", {rsp_valid0, rsp_write0, rsp_err0, rsp_rdata0, psel0});
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid0, busy0} !== 2'b00) begin errors++; $display("FAIL l0_done got %b want 00", {rsp_valid0, busy0}); end
    push0(1'b1, 8'h21, 32'h55);
    repeat (4) @(negedge clk);
    checks++;
    if ({rsp_valid0, rsp_write0, rsp_err0, rsp_rdata0} !== {3'b110, 32'h0}) begin
      errors++; $display("FAIL l0_wr got %h", {rsp_valid0, rsp_write0, rsp_err0, rsp_rdata0});
    end
  endtask

  task automatic test_random();
    logic [7:0] a;
    wait_mode = -1;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
      push(1'($urandom_range(0, 1)), a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      model[i] = 32'h0;
      sregs[i] = 32'h0;
    end
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    c0_valid = 1'b0; c0_write = 1'b0; c0_addr = '0; c0_wdata = '0;
    test_reset();
    test_single_write();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_timeout(1'b1);
    test_timeout(1'b0);
    test_reset_mid();
    test_lat0();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
